hc_shift_register: RTL
======================

HC_SHIFT_REGISTER -- requirements
Module: hc_shift_register

Interface
REQ-001 SHALL have parameter WIDTH, default 8, register width in bits (legal range 2..64).
REQ-002 SHALL have parameter RESET_VAL, default WIDTH'b0, value loaded into q by reset (per-bit preset/clear selection).
REQ-003 SHALL have port cp  input  1  clock; all state changes on rising edge except reset.
REQ-004 SHALL have port mr  input  1  asynchronous active-high master reset.
REQ-005 SHALL have port ce  input  1  synchronous clock enable, active-high.
REQ-006 SHALL have port s  input  2  mode select: 00 hold, 01 shift right, 10 shift left, 11 parallel load.
REQ-007 SHALL have port dsr  input  1  serial input for shift right.
REQ-008 SHALL have port dsl  input  1  serial input for shift left.
REQ-009 SHALL have port rot  input  1  rotate select (used only per REQ-027).
REQ-010 SHALL have port d  input  WIDTH  parallel load data.
REQ-011 SHALL have port q  output  WIDTH  registered state.
REQ-012 SHALL have port qn  output  WIDTH  bitwise complement of q.
REQ-013 SHALL have port cnt  output  $clog2(WIDTH+1)  shifts since last load/reset, saturating.
REQ-014 SHALL have port full  output  1  high when cnt equals WIDTH.

Function
REQ-015 SHALL update q, cnt and full only on a rising cp edge with ce=1 and mr=0; one-edge latency from inputs to q.
REQ-016 SHALL, with ce=0, hold q, cnt and full regardless of s, d, dsr, dsl, rot.
REQ-017 SHALL, for s=00, hold q and cnt.
REQ-018 SHALL, for s=01, set q <= {q[WIDTH-2:0], dsr} (bit 0 takes serial input, data moves toward MSB).
REQ-019 SHALL, for s=10, set q <= {dsl, q[WIDTH-1:1]} (MSB takes serial input, data moves toward bit 0).
REQ-020 SHALL, for s=11, set q <= d and cnt <= 0.
REQ-021 SHALL, for each shift (s=01 or 10), increment cnt by 1, saturating at WIDTH (no wrap-around to 0).
REQ-022 SHALL drive full = (cnt == WIDTH) from registered cnt, no combinational path from inputs.
REQ-023 SHALL drive qn = ~q combinationally, always consistent with q including during reset.

Reset
REQ-024 SHALL, while mr=1, force q=RESET_VAL, cnt=0, full=0 immediately, independent of cp.
REQ-025 SHALL give mr priority over any coincident cp edge; a load or shift at that edge is discarded.
REQ-026 SHALL, after mr falls, hold reset values until the first enabled rising cp edge; reset mid-shift-sequence restarts cnt at 0.

Configuration
REQ-027 SHALL, with macro HC_SHIFT_ROTATE_EN defined, replace the serial input by the outgoing end bit when rot=1 (s=01: bit 0 <= q[WIDTH-1]; s=10: MSB <= q[0]); rotations count per REQ-021.
REQ-028 SHALL, with HC_SHIFT_ROTATE_EN undefined, keep port rot present but ignored; shifts always use dsr/dsl.

Verification (WIDTH=8, RESET_VAL=8'hA5)
REQ-029 SHALL test: mr pulse between cp edges -> q=A5, qn=5A, cnt=0, full=0 without any cp edge.
REQ-030 SHALL test: load d=3C, then 9 edges s=01 dsr=1 -> q=FF after 8th, cnt 1..8, full=1 from 8th, cnt stays 8 on 9th.
REQ-031 SHALL test: load 81, one edge s=10 dsl=0 -> q=40, cnt=1; then s=00 -> q=40, cnt=1 unchanged.
REQ-032 SHALL test: ce=0, s=11, d=00 for 3 edges -> q and cnt unchanged.
REQ-033 SHALL test: load 81, rot=1, s=01 dsr=0 one edge -> q=03 with HC_SHIFT_ROTATE_EN, q=02 without.
REQ-034 SHALL test: mr rising coincident with cp edge carrying s=11 d=FF -> q=A5, cnt=0.

Source files
------------

// File: rtl/hc_shift_register.sv
// ============================================================================
// Module      : hc_shift_register
// Description : Universal shift register with hold, shift right/left, parallel
//               load and a saturating shift counter. Define HC_SHIFT_ROTATE_EN
//               to let rot=1 feed the outgoing end bit back in.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hc_shift_register #(
  parameter int              WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                         cp,
  input  logic                         mr,
  input  logic                         ce,
  input  logic [1:0]                   s,
  input  logic                         dsr,
  input  logic                         dsl,
  input  logic                         rot,
  input  logic [WIDTH-1:0]             d,
  output logic [WIDTH-1:0]             q,
  output logic [WIDTH-1:0]             qn,
  output logic [$clog2(WIDTH+1)-1:0]   cnt,
  output logic                         full
);

  localparam int CNT_W = $clog2(WIDTH+1);
  localparam logic [CNT_W-1:0] C_CNT_MAX = CNT_W'(WIDTH);

  localparam logic [1:0] C_HOLD  = 2'b00;
  localparam logic [1:0] C_SHR   = 2'b01;
  localparam logic [1:0] C_SHL   = 2'b10;
  localparam logic [1:0] C_LOAD  = 2'b11;

  logic [WIDTH-1:0] r_q;
  logic [CNT_W-1:0] r_cnt;
  logic             w_sr_in;
  logic             w_sl_in;
  logic [CNT_W-1:0] w_cnt_inc;

`ifdef HC_SHIFT_ROTATE_EN
  assign w_sr_in = rot ? r_q[WIDTH-1] : dsr;
  assign w_sl_in = rot ? r_q[0]       : dsl;
`else
  logic w_unused_rot;
  assign w_unused_rot = rot;
  assign w_sr_in      = dsr;
  assign w_sl_in      = dsl;
`endif

  // Counter saturates at WIDTH rather than wrapping back to zero.
  assign w_cnt_inc = (r_cnt == C_CNT_MAX) ? r_cnt : r_cnt + CNT_W'(1);

  always_ff @(posedge cp or posedge mr) begin
    if (mr) begin
      r_q   <= RESET_VAL;
      r_cnt <= '0;
    end else if (ce) begin
      case (s)
        C_HOLD: begin
          r_q   <= r_q;
          r_cnt <= r_cnt;
        end
        C_SHR: begin
          r_q   <= {r_q[WIDTH-2:0], w_sr_in};
          r_cnt <= w_cnt_inc;
        end
        C_SHL: begin
          r_q   <= {w_sl_in, r_q[WIDTH-1:1]};
          r_cnt <= w_cnt_inc;
        end
        C_LOAD: begin
          r_q   <= d;
          r_cnt <= '0;
        end
        default: begin
          r_q   <= r_q;
          r_cnt <= r_cnt;
        end
      endcase
    end
  end

  // full decodes only registered state, so it never sees input glitches.
  assign q    = r_q;
  assign qn   = ~r_q;
  assign cnt  = r_cnt;
  assign full = (r_cnt == C_CNT_MAX);

endmodule

`default_nettype wire
